// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pkg
// Purpose  : Shared state encoding and default geometry for the systolic
//            array sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    localparam int ROWS_DEF   = 4;
    localparam int COLS_DEF   = 4;
    localparam int DW_DEF     = 8;
    localparam int AW_DEF     = 8;
    localparam int PE_LAT_DEF = 1;

    // Accumulator width of the downstream result capture stage
    localparam int ACCW = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WLOAD   = 3'd1,
        S_WSETTLE = 3'd2,
        S_STREAM  = 3'd3,
        S_DRAIN   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/systolic_ctrl_skew_line.sv
`default_nettype none
// ============================================================================
// Module   : skew_line
// Purpose  : DEPTH-stage shift register carrying a data word and its valid
//            bit; DEPTH=0 is a straight wire. Output data is zero whenever
//            the output valid is low.
// Revision : 1.0 - initial release
// ============================================================================
module skew_line #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         pending
);

    generate
        if (DEPTH == 0) begin : g_wire
            wire unused_clk_rst = clk ^ rst;
            assign out_valid = in_valid;
            assign out_data  = in_valid ? in_data : '0;
            assign pending   = 1'b0;
        end else begin : g_shift
            logic [DEPTH-1:0]        v;
            logic [DEPTH-1:0][W-1:0] d;

            // Shift valid and data one stage per clock
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v <= '0;
                    d <= '0;
                end else begin
                    v[0] <= in_valid;
                    d[0] <= in_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        v[i] <= v[i-1];
                        d[i] <= d[i-1];
                    end
                end
            end

            assign out_valid = v[DEPTH-1];
            assign out_data  = v[DEPTH-1] ? d[DEPTH-1] : '0;
            assign pending   = |v;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_ctrl
// Purpose  : Job sequencer for a weight-stationary ROWS x COLS systolic array:
//            loads weights bottom row first, then streams activation vectors
//            through per-row skew lines and flags valid bottom-row results.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int ROWS   = ROWS_DEF,
    parameter int COLS   = COLS_DEF,
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int PE_LAT = PE_LAT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [AW-1:0]      num_vec,
    output logic               busy,
    output logic               done,
    output logic               w_rd_en,
    output logic [AW-1:0]      w_rd_addr,
    input  logic [COLS*DW-1:0] w_rd_data,
    output logic               pe_wwrite,
    output logic [COLS*DW-1:0] pe_win,
    output logic               a_rd_en,
    output logic [AW-1:0]      a_rd_addr,
    input  logic [ROWS*DW-1:0] a_rd_data,
    output logic [ROWS-1:0]    pe_active,
    output logic [ROWS*DW-1:0] pe_datain,
    output logic [COLS-1:0]    col_valid
);

    localparam int SETTLE = ROWS * PE_LAT;
    localparam int CHAIN  = (ROWS + COLS - 1) * PE_LAT;
    localparam int CW     = $clog2(ROWS + SETTLE + 1) + 1;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   phase_cnt;
    logic [AW-1:0]   vec_cnt;
    logic [AW-1:0]   n_reg;
    logic            wr_d;
    logic            a_valid_d;
    logic [CHAIN-1:0] chain;
    logic [ROWS-1:0] skew_pend;
    logic            drain_empty;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state decode and buffer-side strobes
    always_comb begin
        state_nx  = state;
        w_rd_en   = 1'b0;
        w_rd_addr = '0;
        a_rd_en   = 1'b0;
        a_rd_addr = '0;
        busy      = (state != S_IDLE);
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_WLOAD;
            end
            S_WLOAD: begin
                // ROWS reads, plus one cycle for the last returned row to be written
                if (phase_cnt < CW'(ROWS)) begin
                    w_rd_en   = 1'b1;
                    w_rd_addr = AW'(ROWS - 1) - AW'(phase_cnt);
                end else begin
                    state_nx = S_WSETTLE;
                end
            end
            S_WSETTLE: begin
                if (phase_cnt == CW'(SETTLE - 1))
                    state_nx = (n_reg == '0) ? S_DONE : S_STREAM;
            end
            S_STREAM: begin
                a_rd_en   = 1'b1;
                a_rd_addr = vec_cnt;
                if (vec_cnt == n_reg - 1'b1) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_empty) state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Job length latch, phase/vector counters and read-return flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_reg     <= '0;
            phase_cnt <= '0;
            vec_cnt   <= '0;
            wr_d      <= 1'b0;
            a_valid_d <= 1'b0;
        end else begin
            if (state == S_IDLE && start) n_reg <= num_vec;
            phase_cnt <= (state_nx != state) ? '0 : phase_cnt + 1'b1;
            vec_cnt   <= (state == S_STREAM) ? vec_cnt + 1'b1 : '0;
            wr_d      <= w_rd_en;
            a_valid_d <= a_rd_en;
        end
    end

    assign pe_wwrite = wr_d;
    assign pe_win    = wr_d ? w_rd_data : '0;

    // Row-0 activity delay chain feeding the column result strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain[0] <= a_valid_d;
            for (int i = 1; i < CHAIN; i++) chain[i] <= chain[i-1];
        end
    end

    generate
        for (genvar c = 0; c < COLS; c++) begin : g_col
            assign col_valid[c] = chain[(ROWS + c) * PE_LAT - 1];
        end
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            skew_line #(
                .DEPTH (r * PE_LAT),
                .W     (DW)
            ) u_skew (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (a_valid_d),
                .in_data   (a_rd_data[r*DW +: DW]),
                .out_valid (pe_active[r]),
                .out_data  (pe_datain[r*DW +: DW]),
                .pending   (skew_pend[r])
            );
        end
    endgenerate

    // Pipeline is empty after this edge when only the final column tap may still be set
    always_comb begin
        drain_empty = !a_valid_d && (skew_pend == '0);
        for (int i = 0; i < CHAIN - 1; i++) begin
            if (chain[i]) drain_empty = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_ctrl
// Purpose  : Self-checking bench for systolic_ctrl with buffer models and a
//            queue-based scoreboard for weights, skewed data and result strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_ctrl;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int DW     = 8;
    localparam int AW     = 8;
    localparam int PE_LAT = 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [AW-1:0]      num_vec = '0;
    logic               busy, done, w_rd_en, pe_wwrite, a_rd_en;
    logic [AW-1:0]      w_rd_addr, a_rd_addr;
    logic [COLS*DW-1:0] w_rd_data = '0;
    logic [COLS*DW-1:0] pe_win;
    logic [ROWS*DW-1:0] a_rd_data = '0;
    logic [ROWS-1:0]    pe_active;
    logic [ROWS*DW-1:0] pe_datain;
    logic [COLS-1:0]    col_valid;

    systolic_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW), .PE_LAT(PE_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
        .busy(busy), .done(done),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .pe_wwrite(pe_wwrite), .pe_win(pe_win),
        .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
        .pe_active(pe_active), .pe_datain(pe_datain), .col_valid(col_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    // Buffer contents: weight row i is 8'h10*(i+1) in every lane,
    // activation vector v lane r is 4v+r+1
    logic [COLS*DW-1:0] wmem [ROWS];
    logic [ROWS*DW-1:0] amem [16];
    initial begin
        for (int i = 0; i < ROWS; i++) begin
            logic [DW-1:0] b;
            b = DW'(8'h10 * (i + 1));
            wmem[i] = {COLS{b}};
        end
        for (int v = 0; v < 16; v++)
            for (int r = 0; r < ROWS; r++)
                amem[v][r*DW +: DW] = DW'(4 * v + r + 1);
    end

    typedef struct { int cyc; logic [DW-1:0] val; }      aexp_t;
    typedef struct { int cyc; logic [COLS*DW-1:0] val; } wexp_t;
    wexp_t w_q [$];
    aexp_t row_q [ROWS][$];
    int    col_q [COLS][$];

    // Buffer models with 1-cycle read latency; each read pushes its expected effects
    always @(posedge clk) begin
        if (w_rd_en) begin
            w_rd_data <= wmem[w_rd_addr[1:0]];
            w_q.push_back('{cyc: cyc + 1, val: wmem[w_rd_addr[1:0]]});
        end
        if (a_rd_en) begin
            a_rd_data <= amem[a_rd_addr[3:0]];
            for (int r = 0; r < ROWS; r++)
                row_q[r].push_back('{cyc: cyc + 1 + r * PE_LAT,
                                     val: amem[a_rd_addr[3:0]][r*DW +: DW]});
            for (int c = 0; c < COLS; c++)
                col_q[c].push_back(cyc + 1 + (ROWS + c) * PE_LAT);
        end
    end

    wexp_t we;
    aexp_t ae;
    int    ce;

    // Scoreboard: compare every strobe the array sees against the queued expectation
    always @(negedge clk) begin
        if (!rst) begin
            n_chk++;
            if (pe_wwrite) begin
                if (w_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_weight: pe_wwrite at cyc %0d with nothing expected", cyc);
                end else begin
                    we = w_q.pop_front();
                    if (we.cyc !== cyc || we.val !== pe_win) begin
                        n_fail++;
                        $display("FAIL sb_weight: got %h at cyc %0d, expected %h at cyc %0d",
                                 pe_win, cyc, we.val, we.cyc);
                    end
                end
            end else if (pe_win !== '0) begin
                n_fail++;
                $display("FAIL sb_weight_idle: pe_win=%h, expected 0", pe_win);
            end
            for (int r = 0; r < ROWS; r++) begin
                n_chk++;
                if (pe_active[r]) begin
                    if (row_q[r].size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_row%0d: active at cyc %0d with nothing expected", r, cyc);
                    end else begin
                        ae = row_q[r].pop_front();
                        if (ae.cyc !== cyc || ae.val !== pe_datain[r*DW +: DW]) begin
                            n_fail++;
                            $display("FAIL sb_row%0d: got %h at cyc %0d, expected %h at cyc %0d",
                                     r, pe_datain[r*DW +: DW], cyc, ae.val, ae.cyc);
                        end
                    end
                end else if (pe_datain[r*DW +: DW] !== '0) begin
                    n_fail++;
                    $display("FAIL sb_row%0d_idle: datain=%h, expected 0", r, pe_datain[r*DW +: DW]);
                end
            end
            for (int c = 0; c < COLS; c++) begin
                if (col_valid[c]) begin
                    n_chk++;
                    if (col_q[c].size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_col%0d: valid at cyc %0d with nothing expected", c, cyc);
                    end else begin
                        ce = col_q[c].pop_front();
                        if (ce !== cyc) begin
                            n_fail++;
                            $display("FAIL sb_col%0d: valid at cyc %0d, expected cyc %0d", c, cyc, ce);
                        end
                    end
                end
            end
        end
    end

    // Per-cycle log of one job, indexed by cycle number (1 = first cycle after start edge)
    logic               busy_l [0:63];
    logic               done_l [0:63];
    logic               wen_l  [0:63];
    logic [AW-1:0]      waddr_l[0:63];
    logic               wwr_l  [0:63];
    logic [COLS*DW-1:0] win_l  [0:63];
    logic               aen_l  [0:63];
    logic [AW-1:0]      aaddr_l[0:63];
    logic [ROWS-1:0]    act_l  [0:63];
    logic [COLS-1:0]    col_l  [0:63];
    logic [DW-1:0]      d2_l   [0:63];

    task automatic flush_sb();
        w_q.delete();
        for (int r = 0; r < ROWS; r++) row_q[r].delete();
        for (int c = 0; c < COLS; c++) col_q[c].delete();
    endtask

    task automatic run_job(input int n, input int ncyc, input bit hold, input bit pulses,
                           output int done_cyc, output int ndone);
        done_cyc = -1;
        ndone    = 0;
        @(negedge clk);
        num_vec = AW'(n);
        start   = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int rel = 1; rel <= ncyc; rel++) begin
            @(negedge clk);
            busy_l[rel]  = busy;      done_l[rel]  = done;
            wen_l[rel]   = w_rd_en;   waddr_l[rel] = w_rd_addr;
            wwr_l[rel]   = pe_wwrite; win_l[rel]   = pe_win;
            aen_l[rel]   = a_rd_en;   aaddr_l[rel] = a_rd_addr;
            act_l[rel]   = pe_active; col_l[rel]   = col_valid;
            d2_l[rel]    = pe_datain[2*DW +: DW];
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = rel;
            end
            if (pulses) start = (rel == 5 || rel == 15 || rel == 20);
            if (hold && ndone == 2) start = 1'b0;
        end
        start = 1'b0;
        n_chk++;
        if (w_q.size() != 0 || row_q[0].size() != 0 || row_q[ROWS-1].size() != 0 ||
            col_q[0].size() != 0 || col_q[COLS-1].size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: entries left w=%0d row0=%0d col3=%0d, expected 0",
                     w_q.size(), row_q[0].size(), col_q[COLS-1].size());
        end
    endtask

    task automatic test_reset();
        int dc, nd;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({busy, done, w_rd_en, pe_wwrite, a_rd_en} !== 5'b0 || w_rd_addr !== '0 ||
            a_rd_addr !== '0 || pe_win !== '0 || pe_active !== '0 ||
            pe_datain !== '0 || col_valid !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b act=%b col=%b, expected all 0",
                     busy, done, pe_active, col_valid);
        end
        rst = 1'b0;
        @(negedge clk);
        num_vec = 8'd5;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int rel = 1; rel <= 12; rel++) @(negedge clk);
        n_chk++;
        if (pe_active !== 4'b0011) begin
            n_fail++;
            $display("FAIL reset_pre_act: pe_active=%b, expected 0011", pe_active);
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if (busy !== 1'b0 || pe_active !== '0 || col_valid !== '0 || done !== 1'b0 ||
            pe_datain !== '0 || a_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: busy=%b act=%b col=%b done=%b, expected 0",
                     busy, pe_active, col_valid, done);
        end
        flush_sb();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: done=%b busy=%b, expected 0", done, busy);
            end
        end
        rst = 1'b0;
        run_job(1, 22, 1'b0, 1'b0, dc, nd);
        n_chk++;
        if (dc !== 19 || nd !== 1) begin
            n_fail++;
            $display("FAIL reset_rerun: done at %0d count %0d, expected 19 count 1", dc, nd);
        end
    endtask

    task automatic test_wload();
        int dc, nd;
        logic [DW-1:0]      b;
        logic [COLS*DW-1:0] ew;
        run_job(1, 22, 1'b0, 1'b0, dc, nd);
        for (int c = 1; c <= 8; c++) begin
            n_chk++;
            if (wen_l[c] !== (c <= ROWS) || (c <= ROWS && waddr_l[c] !== AW'(ROWS - c))) begin
                n_fail++;
                $display("FAIL wload_rd c%0d: en=%b addr=%0d, expected en=%b addr=%0d",
                         c, wen_l[c], waddr_l[c], (c <= ROWS), ROWS - c);
            end
            b  = (c >= 2 && c <= ROWS + 1) ? DW'(8'h10 * (ROWS + 2 - c)) : '0;
            ew = {COLS{b}};
            n_chk++;
            if (wwr_l[c] !== (c >= 2 && c <= ROWS + 1) || win_l[c] !== ew) begin
                n_fail++;
                $display("FAIL wload_wr c%0d: wwrite=%b win=%h, expected %b %h",
                         c, wwr_l[c], win_l[c], (c >= 2 && c <= ROWS + 1), ew);
            end
        end
    endtask

    task automatic test_single();
        int dc, nd;
        run_job(1, 22, 1'b0, 1'b0, dc, nd);
        n_chk++;
        if (aen_l[10] !== 1'b1 || aaddr_l[10] !== '0) begin
            n_fail++;
            $display("FAIL single_rd: en=%b addr=%0d at c10, expected 1 0", aen_l[10], aaddr_l[10]);
        end
        for (int c = 1; c <= 22; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                n_chk++;
                if (act_l[c][r] !== (c == 11 + r)) begin
                    n_fail++;
                    $display("FAIL single_act r%0d c%0d: %b, expected %b", r, c, act_l[c][r], (c == 11 + r));
                end
            end
            for (int k = 0; k < COLS; k++) begin
                n_chk++;
                if (col_l[c][k] !== (c == 15 + k)) begin
                    n_fail++;
                    $display("FAIL single_col k%0d c%0d: %b, expected %b", k, c, col_l[c][k], (c == 15 + k));
                end
            end
            n_chk++;
            if (busy_l[c] !== (c <= 19) || aen_l[c] !== (c == 10)) begin
                n_fail++;
                $display("FAIL single_busy c%0d: busy=%b aen=%b, expected %b %b",
                         c, busy_l[c], aen_l[c], (c <= 19), (c == 10));
            end
        end
        n_chk++;
        if (dc !== 19 || nd !== 1) begin
            n_fail++;
            $display("FAIL single_done: at %0d count %0d, expected 19 count 1", dc, nd);
        end
    endtask

    task automatic test_stream3();
        int dc, nd;
        logic [DW-1:0] ed;
        run_job(3, 24, 1'b0, 1'b0, dc, nd);
        for (int c = 1; c <= 24; c++) begin
            ed = (c >= 13 && c <= 15) ? DW'(4 * (c - 13) + 3) : '0;
            n_chk++;
            if (act_l[c][2] !== (c >= 13 && c <= 15) || d2_l[c] !== ed) begin
                n_fail++;
                $display("FAIL stream3_row2 c%0d: act=%b data=%0d, expected %b %0d",
                         c, act_l[c][2], d2_l[c], (c >= 13 && c <= 15), ed);
            end
            n_chk++;
            if (col_l[c][0] !== (c >= 15 && c <= 17)) begin
                n_fail++;
                $display("FAIL stream3_col0 c%0d: %b, expected %b", c, col_l[c][0], (c >= 15 && c <= 17));
            end
        end
        n_chk++;
        if (dc !== 21 || nd !== 1) begin
            n_fail++;
            $display("FAIL stream3_done: at %0d count %0d, expected 21 count 1", dc, nd);
        end
    endtask

    task automatic test_empty_job();
        int dc, nd;
        run_job(0, 13, 1'b0, 1'b0, dc, nd);
        for (int c = 1; c <= 13; c++) begin
            n_chk++;
            if (aen_l[c] !== 1'b0 || act_l[c] !== '0 || col_l[c] !== '0 || busy_l[c] !== (c <= 10)) begin
                n_fail++;
                $display("FAIL empty_job c%0d: aen=%b act=%b col=%b busy=%b, expected 0 0 0 %b",
                         c, aen_l[c], act_l[c], col_l[c], busy_l[c], (c <= 10));
            end
        end
        n_chk++;
        if (dc !== 10 || nd !== 1 || wwr_l[5] !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_done: at %0d count %0d wwr5=%b, expected 10 1 1", dc, nd, wwr_l[5]);
        end
    endtask

    task automatic test_back_to_back();
        int dc, nd;
        run_job(2, 45, 1'b1, 1'b0, dc, nd);
        n_chk++;
        if (dc !== 20 || nd !== 2 || done_l[41] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done: first %0d count %0d d41=%b, expected 20 2 1", dc, nd, done_l[41]);
        end
        n_chk++;
        if (busy_l[21] !== 1'b0 || busy_l[22] !== 1'b1 || busy_l[42] !== 1'b0 || busy_l[45] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_busy: b21=%b b22=%b b42=%b b45=%b, expected 0 1 0 0",
                     busy_l[21], busy_l[22], busy_l[42], busy_l[45]);
        end
        run_job(2, 26, 1'b0, 1'b1, dc, nd);
        n_chk++;
        if (dc !== 20 || nd !== 1) begin
            n_fail++;
            $display("FAIL busy_start: done at %0d count %0d, expected 20 count 1", dc, nd);
        end
        for (int c = 21; c <= 26; c++) begin
            n_chk++;
            if (busy_l[c] !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_start_idle c%0d: busy=%b, expected 0", c, busy_l[c]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wload();
        test_single();
        test_stream3();
        test_empty_job();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
